sha256_stream_core: RTL
=======================

SHA256_STREAM_CORE -- requirements
Module: sha256_stream_core

Interface
REQ-001 SHALL provide parameter ROUNDS_PER_CYCLE, default 1, compression rounds per clock; legal values 1, 2, 4, 8; any other value SHALL fail elaboration.
REQ-002 SHALL provide parameter OUT_REG, default 1, 1 = hash_out held in an output register until consumed.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 chunk_in  input  512  pre-padded message block, word 0 in bits [511:480].
REQ-006 chunk_valid  input  1  chunk_in, chunk_first, chunk_last, mode_224 valid.
REQ-007 chunk_ready  output  1  core accepts a chunk this cycle.
REQ-008 chunk_first  input  1  block starts a new message; chain from IV.
REQ-009 chunk_last  input  1  block ends the message; produce digest.
REQ-010 mode_224  input  1  0 = SHA-256, 1 = SHA-224; sampled only with a first chunk.
REQ-011 hash_out  output  256  digest; SHA-224 digest in [255:32], [31:0] = 0.
REQ-012 hash_out_valid  output  1  hash_out holds a completed digest.
REQ-013 hash_out_ready  input  1  consumer takes the digest.
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement states IDLE, ROUND, FINAL, DONE.
REQ-016 chunk_ready SHALL equal 1 only in IDLE; a chunk is accepted on an edge with chunk_valid=1 and chunk_ready=1.
REQ-017 On accept: load W[0..15] from chunk_in, load a..h from IV (per latched mode) if chunk_first else from chain registers, clear round counter, go to ROUND.
REQ-018 In ROUND each edge SHALL perform ROUNDS_PER_CYCLE FIPS 180-4 rounds with on-the-fly 16-word schedule; after round 63 go to FINAL; N = 64/ROUNDS_PER_CYCLE edges in ROUND.
REQ-019 In FINAL one edge SHALL add a..h to chain words mod 2^32; if latched last go to DONE with hash_out_valid=1, else go to IDLE.
REQ-020 Latency: hash_out_valid SHALL rise N+1 edges after the accepting edge (65 for R=1, 9 for R=8).
REQ-021 In DONE hash_out and hash_out_valid SHALL remain stable until an edge with hash_out_ready=1, then go to IDLE and drop hash_out_valid.
REQ-022 With OUT_REG=0 hash_out SHALL track the chain registers combinationally; handshake unchanged.
REQ-023 chunk_first and chunk_last both 1 SHALL be a legal single-block message.
REQ-024 A non-first chunk after a completed message SHALL chain from the previous final hash (no implicit IV reload).
REQ-025 mode_224 SHALL be latched on a first-chunk accept and held for the message; value on later chunks ignored.
REQ-026 Inputs SHALL be ignored outside IDLE; chunk_in need not be held after accept.
REQ-027 hash_out_ready outside DONE SHALL have no effect.
REQ-028 All additions modulo 2^32; rotations/shifts per FIPS 180-4; K table internal constant.

Reset
REQ-029 rst=0 SHALL immediately force IDLE, chunk_ready=1 after release, hash_out_valid=0, busy=0, hash_out=0, chain registers to SHA-256 IV, latched mode=0, round counter=0.
REQ-030 Reset asserted mid-ROUND or in DONE SHALL discard the in-progress message; no digest emitted.

Verification
REQ-031 R=1, single chunk 0x616263 80...00 0018, first=last=1 -> 65 edges later hash_out=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
REQ-032 Same chunk, mode_224=1 -> hash_out[255:32]=23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, [31:0]=0.
REQ-033 Two-block message "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" (first, then last) for R=1,2,4,8 -> 248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1; check chunk_ready low between blocks and latency N+1.
REQ-034 Empty message block 0x80 00...00, hash_out_ready held 0 for 10 cycles -> hash_out stable at e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855, chunk_ready=0, then released after ready.
REQ-035 Assert rst at round 30 of "abc", then resend "abc" -> no valid before reset; correct "abc" digest after resend.
REQ-036 chunk_valid toggled while busy with garbage data -> digest unchanged from REQ-031.

Source files
------------

// File: rtl/sha256_stream_core.sv
// SHA-256/224 block core: one pre-padded 512-bit chunk per accept, chained.
// Ports: clk, rst (async low); chunk_in/_valid/_ready/_first/_last, mode_224;
// hash_out/_valid/_ready digest handshake; busy high outside IDLE.
module sha256_stream_core #(
  parameter int ROUNDS_PER_CYCLE = 1,
  parameter int OUT_REG          = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [511:0] chunk_in,
  input  logic         chunk_valid,
  output logic         chunk_ready,
  input  logic         chunk_first,
  input  logic         chunk_last,
  input  logic         mode_224,
  output logic [255:0] hash_out,
  output logic         hash_out_valid,
  input  logic         hash_out_ready,
  output logic         busy
);
  localparam int R = ROUNDS_PER_CYCLE;

  if (R != 1 && R != 2 && R != 4 && R != 8) begin : g_bad_r
    $error("ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  typedef logic [7:0][31:0]  st_t;
  typedef logic [15:0][31:0] win_t;
  typedef enum logic [1:0] {IDLE, ROUND, FINAL, DONE} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  // Packed order: element [0] is H0.
  localparam st_t IV256 = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667
  };
  localparam st_t IV224 = {
    32'hbefa4fa4, 32'h64f98fa7, 32'h68581511, 32'hffc00b31,
    32'hf70e5939, 32'h3070dd17, 32'h367cd507, 32'hc1059ed8
  };

  function automatic logic [31:0] rotr(logic [31:0] x, int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic st_t sha_round(st_t v, logic [31:0] k,
                                    logic [31:0] w);
    logic [31:0] t1, t2;
    t1 = v[7] + bsig1(v[4])
       + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k + w;
    t2 = bsig0(v[0])
       + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
    return {v[6:4], v[3] + t1, v[2:0], t1 + t2};
  endfunction

  function automatic win_t load_win(logic [511:0] c);
    win_t w;
    for (int i = 0; i < 16; i++) w[i] = c[511 - 32*i -: 32];
    return w;
  endfunction

  function automatic logic [255:0] fmt(st_t h, logic m);
    logic [255:0] o;
    for (int i = 0; i < 8; i++) o[255 - 32*i -: 32] = h[i];
    if (m) o[31:0] = '0;
    return o;
  endfunction

  state_t     state_q;
  logic [5:0] cnt_q;
  st_t        v_q, h_q;
  win_t       w_q;
  logic       mode_q, last_q;
  logic       rdy_q, busy_q, hv_q;

  st_t        v_d, h_sum;
  win_t       w_d;
  logic [5:0] ki;

  // w_q[0] is always the schedule word of the next round to run.
  always_comb begin
    v_d = v_q;
    w_d = w_q;
    ki  = cnt_q;
    for (int r = 0; r < R; r++) begin
      v_d = sha_round(v_d, K[ki], w_d[0]);
      w_d = {ssig1(w_d[14]) + w_d[9] + ssig0(w_d[1]) + w_d[0],
             w_d[15:1]};
      ki  = ki + 6'd1;
    end
    for (int i = 0; i < 8; i++) h_sum[i] = h_q[i] + v_q[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      v_q     <= '0;
      w_q     <= '0;
      h_q     <= IV256;
      mode_q  <= 1'b0;
      last_q  <= 1'b0;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      hv_q    <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: if (chunk_valid) begin
          w_q     <= load_win(chunk_in);
          cnt_q   <= '0;
          last_q  <= chunk_last;
          if (chunk_first) begin
            mode_q <= mode_224;
            v_q    <= mode_224 ? IV224 : IV256;
            h_q    <= mode_224 ? IV224 : IV256;
          end else begin
            v_q    <= h_q;
          end
          state_q <= ROUND;
          rdy_q   <= 1'b0;
          busy_q  <= 1'b1;
        end
        ROUND: begin
          v_q   <= v_d;
          w_q   <= w_d;
          cnt_q <= cnt_q + 6'(R);
          if (cnt_q == 6'(64 - R)) state_q <= FINAL;
        end
        FINAL: begin
          h_q <= h_sum;
          if (last_q) begin
            state_q <= DONE;
            hv_q    <= 1'b1;
          end else begin
            state_q <= IDLE;
            rdy_q   <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        DONE: if (hash_out_ready) begin
          state_q <= IDLE;
          hv_q    <= 1'b0;
          rdy_q   <= 1'b1;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic [255:0] hout_q;
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) hout_q <= '0;
      else if (state_q == FINAL && last_q)
        hout_q <= fmt(h_sum, mode_q);
    end
    assign hash_out = hout_q;
  end else begin : g_comb
    assign hash_out = fmt(h_q, mode_q);
  end

  assign chunk_ready    = rdy_q;
  assign busy           = busy_q;
  assign hash_out_valid = hv_q;

endmodule
